ula_seq: RTL and testbench

Sequencer and result register for the 3-bit logic ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's A/B/OP inputs. It captures the ALU's RESU and flags into registers and returns them over a second valid/ready handshake. Shifts by more than one position are done by iterating the ALU's single-bit shift ops. The block sits between the instruction control path and the logic ALU, and owns the architectural flag register.

---
 rtl/ula_seq.sv | 157 +++++++++++++++
 tb/tb_ula_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ula_seq: sequencer and result register for the 3-bit logic ALU.
// Accepts requests over valid/ready, drives the ALU operands/op from
// registers, iterates single-bit shift ops for multi-position shifts and
// returns the captured result plus the architectural flag register.
module ula_seq #(
  parameter int W     = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [CNT_W-1:0] req_cnt,
  output logic [W-1:0]     ula_a,
  output logic [W-1:0]     ula_b,
  output logic [4:0]       ula_op,
  input  logic [W-1:0]     ula_resu,
  input  logic             ula_o,
  input  logic             ula_c,
  input  logic             ula_s,
  input  logic             ula_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_resu,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [4:0] OP_SHL    = 5'b01000;
  localparam logic [4:0] OP_SHR    = 5'b01001;
  localparam logic [4:0] OP_NOS    = 5'b10000;
  localparam logic [4:0] OP_NOZS_A = 5'b10011;
  localparam logic [4:0] OP_NOZS_B = 5'b11111;

  // Flag register bit positions, packed as {O,C,S,Z}
  localparam int F_O = 3;
  localparam int F_C = 2;
  localparam int F_S = 1;
  localparam int F_Z = 0;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] rem;
  logic             req_is_shift;
  logic             exec_is_shift;
  logic             exec_more;
  logic             write_z;
  logic             write_s;
  logic             unused_o;

  // The overflow flag belongs to the arithmetic unit; the ALU's O output is
  // intentionally never captured.
  assign unused_o = ula_o;

  assign req_is_shift  = (req_op == OP_SHL) || (req_op == OP_SHR);
  assign exec_is_shift = (ula_op == OP_SHL) || (ula_op == OP_SHR);
  assign exec_more     = exec_is_shift && (rem > CNT_W'(1));
  assign write_z       = (ula_op != OP_NOZS_A) && (ula_op != OP_NOZS_B);
  assign write_s       = write_z && (ula_op != OP_NOS);

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode: shift-by-zero bypasses EXEC, shifts loop in EXEC
  // until the last position, and RESP waits for the consumer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_is_shift && (req_cnt == '0)) begin
            state_nx = RESP;
          end else begin
            state_nx = EXEC;
          end
        end
      end
      EXEC: begin
        if (!exec_more) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand latch on accept, shift feedback loop through the ALU,
  // and result/flag capture on the final EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ula_a    <= '0;
      ula_b    <= '0;
      ula_op   <= OP_NOS;
      rem      <= '0;
      rsp_resu <= '0;
      flags    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ula_op <= req_op;
            ula_a  <= req_a;
            ula_b  <= req_b;
            rem    <= req_cnt;
            if (req_is_shift && (req_cnt == '0)) begin
              rsp_resu <= req_a;
            end
          end
        end
        EXEC: begin
          if (exec_more) begin
            ula_a      <= ula_resu;
            rem        <= rem - CNT_W'(1);
            flags[F_C] <= ula_c;
          end else begin
            rsp_resu <= ula_resu;
            if (write_z) begin
              flags[F_Z] <= ula_z;
            end
            if (write_s) begin
              flags[F_S] <= ula_s;
            end
            if (exec_is_shift) begin
              flags[F_C] <= ula_c;
            end
            flags[F_O] <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed bench for ula_seq with a behavioural logic ALU and a
// scoreboard of expected {flags, result} pushed at request acceptance.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_op;
  logic [2:0] req_a;
  logic [2:0] req_b;
  logic [1:0] req_cnt;
  logic [2:0] ula_a;
  logic [2:0] ula_b;
  logic [4:0] ula_op;
  logic [2:0] ula_resu;
  logic       ula_o;
  logic       ula_c;
  logic       ula_s;
  logic       ula_z;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_resu;
  logic [3:0] flags;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] sbQueue[$];
  logic [3:0] expFlags = 4'b0000;

  ula_seq #(.W(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_resu(ula_resu), .ula_o(ula_o), .ula_c(ula_c), .ula_s(ula_s), .ula_z(ula_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resu(rsp_resu), .flags(flags)
  );

  always #5 clk = ~clk;

  // Behavioural 3-bit logic ALU result
  function automatic logic [2:0] aluRes(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b);
    case (op)
      5'b01000: aluRes = {a[1:0], 1'b0};
      5'b01001: aluRes = {1'b0, a[2:1]};
      5'b10000: aluRes = 3'b000;
      5'b10001: aluRes = a & b;
      5'b10010: aluRes = a | b;
      5'b10011: aluRes = a ^ b;
      5'b10100: aluRes = ~a;
      5'b11111: aluRes = 3'b001;
      default:  aluRes = 3'b101;
    endcase
  endfunction

  // Behavioural ALU carry: shifted-out bit, otherwise a junk 1 that must be ignored
  function automatic logic aluC(input logic [4:0] op, input logic [2:0] a);
    case (op)
      5'b01000: aluC = a[2];
      5'b01001: aluC = a[0];
      default:  aluC = 1'b1;
    endcase
  endfunction

  // ALU model driving the DUT's result/flag inputs; O is held high to show it is never captured
  always_comb begin
    ula_resu = aluRes(ula_op, ula_a, ula_b);
    ula_c    = aluC(ula_op, ula_a);
    ula_z    = (ula_resu == 3'b000);
    ula_s    = ula_resu[2];
    ula_o    = 1'b1;
  end

  // Reference model of one whole request; updates the expected flag register
  function automatic logic [6:0] predict(input logic [4:0] op, input logic [2:0] a,
                                         input logic [2:0] b, input logic [1:0] cnt);
    logic [2:0] r;
    logic       c;
    r = a;
    c = 1'b0;
    if (op == 5'b01000 || op == 5'b01001) begin
      if (cnt != 2'd0) begin
        for (int i = 0; i < int'(cnt); i++) begin
          c = aluC(op, r);
          r = aluRes(op, r, b);
        end
        expFlags[2] = c;
        expFlags[1] = r[2];
        expFlags[0] = (r == 3'b000);
      end
    end else begin
      r = aluRes(op, a, b);
      if (op != 5'b10011 && op != 5'b11111) begin
        expFlags[0] = (r == 3'b000);
        if (op != 5'b10000) expFlags[1] = r[2];
      end
    end
    predict = {expFlags, r};
  endfunction

  // Single comparison point
  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request (caller at a negedge), wait for acceptance, push the expectation
  task automatic applyStimulus(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b,
                               input logic [1:0] cnt, input int expWait, input bit doPush);
    int waited;
    waited    = 0;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_cnt   = cnt;
    req_valid = 1'b1;
    while (!req_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checkValue("acceptWait", 8'(waited), 8'(expWait));
    @(posedge clk);
    if (doPush) sbQueue.push_back(predict(op, a, b, cnt));
    #1 req_valid = 1'b0;
  endtask

  // Wait for the response, check latency/result/flags, optionally hold backpressure, then handshake
  task automatic checkOutput(input int expLat, input int holdCycles, input bit checkMid,
                             input logic [2:0] midA);
    int         lat;
    logic [6:0] exp;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (checkMid && lat == 2) checkValue("midUlaA", 8'(ula_a), 8'(midA));
    end while (!rsp_valid && lat < 30);
    checkValue("latency", 8'(lat), 8'(expLat));
    checks++;
    assert (sbQueue.size() != 0) else begin
      errors++;
      $error("[TB] FAIL sbUnderflow: observed empty queue expected an entry");
    end
    if (sbQueue.size() != 0) begin
      exp = sbQueue.pop_front();
      checkValue("rspResu", 8'(rsp_resu), 8'(exp[2:0]));
      checkValue("flags", 8'(flags), 8'(exp[6:3]));
      checkValue("reqReadyBusy", 8'(req_ready), 8'd0);
      for (int i = 0; i < holdCycles; i++) begin
        @(negedge clk);
        checkValue("holdValid", 8'(rsp_valid), 8'd1);
        checkValue("holdResu", 8'(rsp_resu), 8'(exp[2:0]));
        checkValue("holdReqReady", 8'(req_ready), 8'd0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_op    = 5'b10001;
    req_a     = 3'b111;
    req_b     = 3'b111;
    req_cnt   = 2'd0;
    rsp_ready = 1'b0;

    // Reset state, with a request offered while reset is held
    repeat (2) @(negedge clk);
    checkValue("rstReqReady", 8'(req_ready), 8'd1);
    checkValue("rstRspValid", 8'(rsp_valid), 8'd0);
    checkValue("rstRspResu", 8'(rsp_resu), 8'd0);
    checkValue("rstFlags", 8'(flags), 8'd0);
    checkValue("rstUlaOp", 8'(ula_op), 8'h10);
    checkValue("rstUlaA", 8'(ula_a), 8'd0);
    checkValue("rstUlaB", 8'(ula_b), 8'd0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    // AND 101 & 011
    applyStimulus(5'b10001, 3'b101, 3'b011, 2'd0, 0, 1'b1);
    checkOutput(2, 0, 1'b0, 3'b000);
    @(negedge clk);

    // Shift left by 2: 011 -> 110 -> 100
    applyStimulus(5'b01000, 3'b011, 3'b000, 2'd2, 0, 1'b1);
    checkOutput(3, 0, 1'b1, 3'b110);
    @(negedge clk);

    // Op 10000 keeps S, then 11111 keeps Z and S (consumer ready early is ignored)
    applyStimulus(5'b10000, 3'b110, 3'b010, 2'd0, 0, 1'b1);
    checkOutput(2, 0, 1'b0, 3'b000);
    @(negedge clk);
    rsp_ready = 1'b1;
    applyStimulus(5'b11111, 3'b000, 3'b000, 2'd0, 0, 1'b1);
    checkOutput(2, 0, 1'b0, 3'b000);
    @(negedge clk);

    // Shift by zero
    applyStimulus(5'b01000, 3'b010, 3'b000, 2'd0, 0, 1'b1);
    checkOutput(1, 0, 1'b0, 3'b000);
    @(negedge clk);

    // Backpressure with a second request waiting
    applyStimulus(5'b01001, 3'b110, 3'b000, 2'd1, 0, 1'b1);
    req_op    = 5'b10100;
    req_a     = 3'b010;
    req_b     = 3'b000;
    req_cnt   = 2'd0;
    req_valid = 1'b1;
    checkOutput(2, 3, 1'b0, 3'b000);
    @(negedge clk);
    checkValue("noAcceptOnHandshake", 8'(ula_op), 8'h09);
    checkValue("idleAfterHandshake", 8'(req_ready), 8'd1);
    applyStimulus(5'b10100, 3'b010, 3'b000, 2'd0, 0, 1'b1);
    checkOutput(2, 0, 1'b0, 3'b000);
    @(negedge clk);

    // Reset in the middle of a 3-position right shift
    applyStimulus(5'b01001, 3'b111, 3'b000, 2'd3, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expFlags = 4'b0000;
    checkValue("midRstValid", 8'(rsp_valid), 8'd0);
    checkValue("midRstFlags", 8'(flags), 8'd0);
    checkValue("midRstReqReady", 8'(req_ready), 8'd1);
    checkValue("midRstUlaOp", 8'(ula_op), 8'h10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkValue("noRspAfterRst", 8'(rsp_valid), 8'd0);
    end
    checkValue("sbDrained", 8'(sbQueue.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
